// File: rtl/jump_pc_sequencer_pkg.sv
// jump_pc_sequencer_pkg: shared encodings and default vectors for the fetch PC sequencer
package jump_pc_sequencer_pkg;
  typedef enum logic [1:0] {JSEL_NONE, JSEL_J_IDX, JSEL_J_REG, JSEL_BRANCH} jsel_t;
  typedef enum logic {ST_RUN, ST_HOLD} state_t;
  localparam logic [31:0] DEF_RESET_PC = 32'h0000_3000;
  localparam logic [31:0] DEF_EXC_PC   = 32'h0000_4180;
endpackage

// File: rtl/jump_pc_sequencer_if.sv
// jump_pc_sequencer_if: D-stage redirect request bus and fetch PC outputs (exc_req only with EXC_VECTOR_EN)
interface jump_pc_sequencer_if;
  import jump_pc_sequencer_pkg::*;
  logic        stall_f;
  jsel_t       jump_sel;
  logic [31:0] pc_d;
  logic [25:0] instr_index;
  logic [15:0] imm16;
  logic [31:0] rs_val;
  logic [31:0] pc_f;
  logic        redirect_pending;
  logic        misalign_err;
`ifdef EXC_VECTOR_EN
  logic        exc_req;
`endif
  modport master (
    output stall_f, jump_sel, pc_d, instr_index, imm16, rs_val,
    input  pc_f, redirect_pending, misalign_err
`ifdef EXC_VECTOR_EN
    , output exc_req
`endif
  );
  modport slave (
    input  stall_f, jump_sel, pc_d, instr_index, imm16, rs_val,
    output pc_f, redirect_pending, misalign_err
`ifdef EXC_VECTOR_EN
    , input exc_req
`endif
  );
endinterface

// File: rtl/jump_pc_sequencer_jump_target_calc.sv
// jump_target_calc: combinational redirect target for J/JAL, JR/JALR and taken branches
module jump_target_calc
  import jump_pc_sequencer_pkg::*;
(
  input  jsel_t       jump_sel,
  input  logic [31:0] pc_d,
  input  logic [25:0] instr_index,
  input  logic [15:0] imm16,
  input  logic [31:0] rs_val,
  output logic [31:0] target
);
  logic [31:0] br_tgt;
  always_comb begin
    br_tgt = pc_d + 32'd4 + {{14{imm16[15]}}, imm16, 2'b00};
    target = jump_sel == JSEL_J_IDX ? {pc_d[31:28], instr_index, 2'b00} :
             jump_sel == JSEL_J_REG ? rs_val : br_tgt;
  end
endmodule

// File: rtl/jump_pc_sequencer.sv
// jump_pc_sequencer: F-stage PC register with stall-safe redirect buffering.
// Optional EXC_VECTOR_EN adds exc_req, which vectors the PC to EXC_PC above all else.
module jump_pc_sequencer
  import jump_pc_sequencer_pkg::*;
#(
  parameter logic [31:0] RESET_PC = DEF_RESET_PC
`ifdef EXC_VECTOR_EN
  , parameter logic [31:0] EXC_PC = DEF_EXC_PC
`endif
) (
  input logic clk,
  input logic reset,
  jump_pc_sequencer_if.slave bus
);
  state_t      st;
  logic [31:0] pc, pend, tgt;
  logic        rp, mis, jump, accept;
  jump_target_calc u_calc (
    .jump_sel(bus.jump_sel), .pc_d(bus.pc_d), .instr_index(bus.instr_index),
    .imm16(bus.imm16), .rs_val(bus.rs_val), .target(tgt)
  );
  // on the release cycle from HOLD the presented jump is ignored, so it is not accepted
  always_comb begin
    jump   = bus.jump_sel != JSEL_NONE;
    accept = jump && (st == ST_RUN || bus.stall_f);
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      pc   <= RESET_PC;
      st   <= ST_RUN;
      pend <= '0;
      rp   <= 1'b0;
      mis  <= 1'b0;
    end
`ifdef EXC_VECTOR_EN
    else if (bus.exc_req) begin
      pc   <= EXC_PC;
      st   <= ST_RUN;
      pend <= '0;
      rp   <= 1'b0;
    end
`endif
    else begin
      if (accept && bus.jump_sel == JSEL_J_REG && tgt[1:0] != 2'b00) mis <= 1'b1;
      if (st == ST_HOLD && !bus.stall_f) begin
        pc <= pend;
        st <= ST_RUN;
        rp <= 1'b0;
      end else if (bus.stall_f) begin
        if (jump) begin
          pend <= tgt;
          st   <= ST_HOLD;
          rp   <= 1'b1;
        end
      end else pc <= jump ? tgt : pc + 32'd4;
    end
  end
  assign bus.pc_f             = pc;
  assign bus.redirect_pending = rp;
  assign bus.misalign_err     = mis;
endmodule

// File: tb/tb_jump_pc_sequencer.sv
// tb_jump_pc_sequencer: directed plan plus randomized run against a queue-based reference model
module tb_jump_pc_sequencer;
  import jump_pc_sequencer_pkg::*;
  logic clk = 0, reset = 1;
  int n_cmp = 0, n_err = 0;
  jump_pc_sequencer_if bus();
  jump_pc_sequencer dut (.clk(clk), .reset(reset), .bus(bus));
  always #5 clk = ~clk;

  logic [31:0] m_pc;
  logic [31:0] m_q[$];
  logic        m_mis;
  logic        exc;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic st, input logic [1:0] sel, input logic [31:0] pd,
                       input logic [25:0] idx, input logic [15:0] imm, input logic [31:0] rs);
    bus.stall_f = st; bus.jump_sel = jsel_t'(sel); bus.pc_d = pd;
    bus.instr_index = idx; bus.imm16 = imm; bus.rs_val = rs;
  endtask

  function automatic logic [31:0] spec_target();
    int signed off;
    off = int'($signed(bus.imm16)) * 4;
    case (bus.jump_sel)
      JSEL_J_IDX: return (bus.pc_d & 32'hF000_0000) | (32'(bus.instr_index) * 4);
      JSEL_J_REG: return bus.rs_val;
      default:    return bus.pc_d + 32'd4 + 32'(off);
    endcase
  endfunction

  // advance the reference model by one clock edge given the currently driven inputs
  task automatic model_edge();
    logic [31:0] t;
    t = spec_target();
    if (exc) begin
      m_pc = DEF_EXC_PC;
      m_q.delete();
    end else if (m_q.size() != 0 && !bus.stall_f) begin
      m_pc = m_q.pop_front();
    end else if (bus.jump_sel != JSEL_NONE) begin
      if (bus.jump_sel == JSEL_J_REG && t[1:0] != 0) m_mis = 1;
      if (bus.stall_f) begin
        m_q.delete();
        m_q.push_back(t);
      end else m_pc = t;
    end else if (!bus.stall_f) m_pc = m_pc + 4;
  endtask

  task automatic check_model(input string tag);
    check({tag, "_pc"}, bus.pc_f, m_pc);
    check({tag, "_rp"}, 32'(bus.redirect_pending), 32'(m_q.size() != 0));
    check({tag, "_mis"}, 32'(bus.misalign_err), 32'(m_mis));
  endtask

  initial begin
    exc = 0;
`ifdef EXC_VECTOR_EN
    bus.exc_req = 0;
`endif
    drive(0, 0, 0, 0, 0, 0);
    step();
    reset = 0;
    check("rst_pc", bus.pc_f, 32'h3000);
    check("rst_rp", 32'(bus.redirect_pending), 0);
    check("rst_mis", 32'(bus.misalign_err), 0);
    for (int i = 1; i <= 3; i++) begin
      step();
      check("free_pc", bus.pc_f, 32'h3000 + 32'(4 * i));
    end
    drive(0, 1, 32'h3004, 26'h0000C10, 0, 0);
    step();
    check("jidx_pc", bus.pc_f, 32'h3040);
    drive(0, 3, 32'h3010, 0, 16'hFFFC, 0);
    step();
    check("br_neg_pc", bus.pc_f, 32'h3004);
    drive(0, 3, 32'h3010, 0, 16'h0003, 0);
    step();
    check("br_pos_pc", bus.pc_f, 32'h3020);
    drive(1, 2, 0, 0, 0, 32'h3100);
    for (int i = 0; i < 2; i++) begin
      step();
      check("hold_rp", 32'(bus.redirect_pending), 1);
      check("hold_pc", bus.pc_f, 32'h3020);
    end
    drive(0, 1, 32'h3004, 26'h1234, 0, 0);
    step();
    check("rel_pc", bus.pc_f, 32'h3100);
    check("rel_rp", 32'(bus.redirect_pending), 0);
    drive(0, 2, 0, 0, 0, 32'h3102);
    step();
    check("mis_set", 32'(bus.misalign_err), 1);
    check("mis_pc", bus.pc_f, 32'h3102);
    drive(0, 1, 32'h3004, 26'h0000C10, 0, 0);
    step();
    check("mis_sticky", 32'(bus.misalign_err), 1);
    check("mis_jpc", bus.pc_f, 32'h3040);
`ifdef EXC_VECTOR_EN
    drive(1, 2, 0, 0, 0, 32'h3200);
    step();
    check("exc_hold_rp", 32'(bus.redirect_pending), 1);
    bus.exc_req = 1;
    step();
    bus.exc_req = 0;
    check("exc_pc", bus.pc_f, 32'h4180);
    check("exc_rp", 32'(bus.redirect_pending), 0);
`endif
    drive(1, 3, 32'h3000, 0, 16'h0010, 0);
    step();
    check("pre_rst_rp", 32'(bus.redirect_pending), 1);
    reset = 1;
    step();
    reset = 0;
    check("midhold_rst_pc", bus.pc_f, 32'h3000);
    check("midhold_rst_rp", 32'(bus.redirect_pending), 0);
    check("midhold_rst_mis", 32'(bus.misalign_err), 0);
    drive(0, 0, 0, 0, 0, 0);
    step();
    check("post_rst_run", bus.pc_f, 32'h3004);
    m_pc = 32'h3004; m_mis = 0; m_q.delete();
    for (int i = 0; i < 400; i++) begin
      logic [31:0] rs;
      rs = $urandom;
      if ($urandom_range(0, 15) != 0) rs[1:0] = 2'b00;
      drive($urandom_range(0, 9) < 4, 2'($urandom_range(0, 3)), $urandom,
            26'($urandom), 16'($urandom), rs);
      if ($urandom_range(0, 2) == 0) bus.jump_sel = JSEL_NONE;
`ifdef EXC_VECTOR_EN
      exc = $urandom_range(0, 24) == 0;
      bus.exc_req = exc;
`endif
      model_edge();
      step();
      check_model("rnd");
    end
    exc = 0;
`ifdef EXC_VECTOR_EN
    bus.exc_req = 0;
`endif
    drive(0, 0, 0, 0, 0, 0);
    model_edge();
    step();
    drive(0, 2, 0, 0, 0, 32'hFFFF_FFFC);
    model_edge();
    step();
    check_model("wrap_set");
    drive(0, 0, 0, 0, 0, 0);
    model_edge();
    step();
    check("wrap_pc", bus.pc_f, 32'h0);
    check_model("wrap");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
